rom_burst_reader: RTL and testbench
===================================

Name: rom_burst_reader

Overview:
- Synthesizable burst fetch controller placed in front of an OpenROM byte-wide ROM macro, for example the SHA-256 round-constant ROM.
- Accepts a (start address, word count) request and issues byte reads to the macro.
- Packs BYTES_PER_WORD bytes per output word, big-endian, and delivers words over a valid/ready stream through a small FIFO.
- Generalises the bare ROM read port to any word width, any read latency and back-pressured bursts.

Parameters:
- ROM_ADDR_WIDTH, 10: byte address width of the macro.
- ROM_DATA_WIDTH, 8: macro data width.
- BYTES_PER_WORD, 4: macro reads packed into one output word (>=1).
- LEN_WIDTH, 8: width of the request word count.
- READ_LATENCY, 1: posedges from the cycle rom_cs/rom_addr are presented to the cycle rom_dout is captured (>=1).
- FIFO_DEPTH, 4: output word FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  clock; all logic posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ROM_ADDR_WIDTH  first byte address.
- req_len  in  LEN_WIDTH  number of words to fetch.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  BYTES_PER_WORD*ROM_DATA_WIDTH  packed word.
- out_last  out  1  head is the final word of the burst.
- busy  out  1  high whenever the state is not IDLE.
- rom_cs  out  1  macro chip select.
- rom_addr  out  ROM_ADDR_WIDTH  macro address.
- rom_dout  in  ROM_DATA_WIDTH  macro data.

Behaviour:
- Reset: state IDLE; FIFO empty; counters and latency pipeline cleared.
- Reset values: req_ready=1, busy=0, out_valid=0, out_last=0, out_data=0, rom_cs=0, rom_addr=0. Reset mid-burst discards everything immediately, with no further rom_cs.
- FSM IDLE -> FETCH -> DRAIN -> IDLE.
- IDLE:
  - On req_valid&&req_ready, latch addr and len.
  - len!=0 goes to FETCH.
  - len==0 is accepted and stays in IDLE, producing no output.
- FETCH:
  - Each cycle, rom_cs=1 with rom_addr=next byte address, but only if a word slot is reserved.
  - A slot is reserved at the first byte of a word. Reservation requires FIFO occupancy + words in flight/partially assembled < FIFO_DEPTH.
  - Otherwise rom_cs=0 and the address is held.
  - Address increments by 1 per issued byte and wraps modulo 2^ROM_ADDR_WIDTH, with no error.
  - After the last byte of word len is issued, go to DRAIN.
- Latency pipeline: a READ_LATENCY-deep shift register of issue tags. When a tag emerges, rom_dout is shifted into the assembly register, first byte into the MSB.
- On the BYTES_PER_WORD-th byte, the word is pushed to the FIFO with a last flag set if it is word len. The push is guaranteed non-overflowing by the reservation rule.
- DRAIN: no reads; go to IDLE in the cycle the last-flagged word is popped (out_valid&&out_ready&&out_last). req_ready=1 on the next cycle.
- FIFO:
  - Push and pop in the same cycle is allowed, including when full.
  - out_data and out_last are stable while out_valid&&!out_ready.
- Throughput: one byte per cycle when unstalled, so one word per BYTES_PER_WORD cycles.
- First-word latency: READ_LATENCY+BYTES_PER_WORD cycles after the request handshake.
- Word counter is LEN_WIDTH bits; max burst is 2^LEN_WIDTH-1 words.
- A request presented outside IDLE is ignored (req_ready=0) and must be held by the requester.

Optional Feature:
- Macro ROM_ABORT_EN.
- When defined:
  - Extra input abort (1 bit).
  - abort=1 in FETCH or DRAIN stops issue the same cycle and discards the FIFO, assembly register and in-flight tags.
  - Next cycle: IDLE, out_valid=0.
  - No out_last word is produced for an aborted burst.
  - abort in IDLE has no effect.
- When undefined: the port is absent and bursts always complete.

Decomposition:
- Package rom_burst_pkg: state enum (IDLE, FETCH, DRAIN), derived localparams WORD_WIDTH=BYTES_PER_WORD*ROM_DATA_WIDTH and FIFO pointer width.
- Sub-module rom_burst_fifo: synchronous FIFO storing {last, data}, with occupancy output used for reservation.

Test Plan:
- Word fetch: BYTES_PER_WORD=4; ROM bytes 0..7 = 42 8A 2F 98 71 37 44 91; req addr=0 len=2, out_ready=1 -> words 0x428A2F98 then 0x71374491; out_last only on the second; req_ready=1 afterwards.
- Back-pressure: len=8, out_ready=0 for 40 cycles -> rom_cs drops after 4 reserved words; with out_ready then 1, all 8 words arrive in order and no word is lost or duplicated.
- Wrap: addr=0x3FE len=1 -> rom_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; word is the packed bytes of those addresses.
- len=0 -> accepted in one cycle; no rom_cs, no out_valid; busy stays 0.
- Reset: rst_n low mid-burst (after 5 bytes issued) -> out_valid=0 and rom_cs=0 immediately; a new req after release fetches correctly.
- READ_LATENCY=3 with ROM_ABORT_EN: abort in DRAIN while 2 words are queued -> out_valid=0 next cycle; a following len=1 request returns the correct single word with out_last=1.

Source files
------------

// File: rtl/rom_burst_pkg.sv
// Shared state encoding, default geometry and helpers for the burst ROM reader.
package rom_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_ROM_DATA_WIDTH = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int WORD_WIDTH         = DEF_BYTES_PER_WORD * DEF_ROM_DATA_WIDTH;
  localparam int FIFO_PTR_WIDTH     = $clog2(DEF_FIFO_DEPTH);

  // Index width that stays legal when the range collapses to a single entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_burst_fifo.sv
// Synchronous word FIFO holding {last, data}; exposes occupancy for slot reservation.
module rom_burst_fifo
  import rom_burst_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst fetch controller for a byte-wide ROM macro: packs big-endian words into a FIFO.
// Optional abort input is enabled by defining ROM_ABORT_EN.
//
// state | meaning
// IDLE  | ready for a request; no reads
// FETCH | issuing byte reads whenever a FIFO word slot is reserved
// DRAIN | all bytes issued; waiting for the last-flagged word to be popped
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 10,
  parameter int ROM_DATA_WIDTH = DEF_ROM_DATA_WIDTH,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int LEN_WIDTH      = 8,
  parameter int READ_LATENCY   = 1,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [ROM_ADDR_WIDTH-1:0]                req_addr,
  input  logic [LEN_WIDTH-1:0]                     req_len,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [BYTES_PER_WORD*ROM_DATA_WIDTH-1:0] out_data,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     rom_cs,
  output logic [ROM_ADDR_WIDTH-1:0]                rom_addr,
  input  logic [ROM_DATA_WIDTH-1:0]                rom_dout
`ifdef ROM_ABORT_EN
  ,
  input  logic                                     abort
`endif
);

  localparam int WORD_W = BYTES_PER_WORD * ROM_DATA_WIDTH;
  localparam int BIW    = idx_width(BYTES_PER_WORD);
  localparam int PTR_W  = idx_width(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  state_t                    state;
  state_t                    state_nxt;
  logic [ROM_ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]      words_left;
  logic [BIW-1:0]            issue_idx;
  logic [CNT_W-1:0]          resv_cnt;
  logic [READ_LATENCY-1:0]   tag_v;
  logic [READ_LATENCY-1:0]   tag_l;
  logic [WORD_W-1:0]         asm_q;
  logic [BIW-1:0]            asm_idx;

  logic                      req_fire;
  logic                      abort_now;
  logic                      issue;
  logic                      issue_first;
  logic                      byte_last;
  logic                      word_final;
  logic                      slot_free;
  logic                      reserve;
  logic                      tag_out;
  logic                      tag_out_last;
  logic                      asm_full;
  logic [WORD_W-1:0]         asm_word;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [WORD_W:0]           fifo_head;

`ifdef ROM_ABORT_EN
  assign abort_now = abort && (state != IDLE);
`else
  assign abort_now = 1'b0;
`endif

  assign req_fire    = req_valid && req_ready;
  assign issue_first = (issue_idx == '0);
  assign byte_last   = (issue_idx == BIW'(BYTES_PER_WORD - 1));
  assign word_final  = (words_left == LEN_WIDTH'(1));
  // Words already queued plus words reserved but not yet pushed must leave room.
  assign slot_free   = ({1'b0, fifo_count} + {1'b0, resv_cnt}) < (CNT_W+1)'(FIFO_DEPTH);
  assign reserve     = issue && issue_first;

  assign tag_out      = tag_v[READ_LATENCY-1];
  assign tag_out_last = tag_l[READ_LATENCY-1];
  assign asm_full     = (asm_idx == BIW'(BYTES_PER_WORD - 1));
  assign asm_word     = (asm_q << ROM_DATA_WIDTH) | WORD_W'(rom_dout);
  assign fifo_push    = tag_out && asm_full && !abort_now;
  assign fifo_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire && (req_len != '0)) state_nxt = FETCH;
      FETCH:   if (abort_now) state_nxt = IDLE;
               else if (issue && byte_last && word_final) state_nxt = DRAIN;
      DRAIN:   if (abort_now || (fifo_pop && out_last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      FETCH:   issue = !abort_now && (!issue_first || slot_free);
      default: ;
    endcase
  end

  assign rom_cs   = issue;
  assign rom_addr = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      words_left <= '0;
      issue_idx  <= '0;
    end else if (req_fire) begin
      addr_q     <= req_addr;
      words_left <= req_len;
      issue_idx  <= '0;
    end else if (abort_now) begin
      issue_idx  <= '0;
    end else if (issue) begin
      addr_q <= addr_q + 1'b1;
      if (byte_last) begin
        issue_idx  <= '0;
        words_left <= words_left - 1'b1;
      end else begin
        issue_idx <= issue_idx + 1'b1;
      end
    end
  end

  // Issue tags ride alongside the macro's read latency so data is captured exactly when valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_l <= '0;
    end else if (abort_now) begin
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= issue;
      tag_l[0] <= issue && byte_last && word_final;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q   <= '0;
      asm_idx <= '0;
    end else if (abort_now) begin
      asm_q   <= '0;
      asm_idx <= '0;
    end else if (tag_out) begin
      if (asm_full) begin
        asm_q   <= '0;
        asm_idx <= '0;
      end else begin
        asm_q   <= asm_word;
        asm_idx <= asm_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_cnt <= '0;
    end else if (abort_now) begin
      resv_cnt <= '0;
    end else begin
      case ({reserve, fifo_push})
        2'b10:   resv_cnt <= resv_cnt + 1'b1;
        2'b01:   resv_cnt <= resv_cnt - 1'b1;
        default: resv_cnt <= resv_cnt;
      endcase
    end
  end

  rom_burst_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_now),
    .push      (fifo_push),
    .push_data ({tag_out_last, asm_word}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[WORD_W-1:0];
  assign out_last  = fifo_head[WORD_W];

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboard bench for rom_burst_reader with a behavioural ROM of matching read latency.
`timescale 1ns/1ps
module tb_rom_burst_reader;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int BPW = 4;
  localparam int LW  = 8;
  localparam int RL  = 3;
  localparam int FD  = 4;
  localparam int WW  = BPW * DW;

  typedef struct packed {
    logic          last;
    logic [WW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          req_ready;
  logic          out_valid;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
`ifdef ROM_ABORT_EN
  logic          abort = 1'b0;
`endif

  logic [DW-1:0] mem [1<<AW];
  logic [AW-1:0] rpipe [RL];
  word_t         exp_q [$];
  logic [AW-1:0] addr_q [$];
  word_t         mon_e;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cs_cnt = 0;

  always #5 clk = ~clk;

  rom_burst_reader #(
    .ROM_ADDR_WIDTH (AW),
    .ROM_DATA_WIDTH (DW),
    .BYTES_PER_WORD (BPW),
    .LEN_WIDTH      (LW),
    .READ_LATENCY   (RL),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout)
`ifdef ROM_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // ROM macro model: address registered, data appears RL posedges later.
  always @(posedge clk) begin
    rpipe[0] <= rom_addr;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rom_dout = mem[rpipe[RL-1]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_cs) begin
        cs_cnt++;
        if (addr_q.size() == 0) chk("addr_unexpected", 64'd1, 64'd0);
        else chk("rom_addr", 64'(rom_addr), 64'(addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("word_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(mon_e.data));
          chk("out_last", 64'(out_last), 64'(mon_e.last));
        end
      end
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input int len);
    for (int w = 0; w < len; w++) begin
      word_t e;
      e.last = (w == len - 1);
      e.data = '0;
      for (int b = 0; b < BPW; b++) begin
        logic [AW-1:0] ad;
        ad = a + AW'(w * BPW + b);
        addr_q.push_back(ad);
        e.data = {e.data[WW-DW-1:0], mem[ad]};
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic do_req(input logic [AW-1:0] a, input int len, input bit chk_lat);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("req_ready_pre", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = LW'(len);
    push_exp(a, len);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (chk_lat) begin
      cyc = 0;
      while (!out_valid && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("first_word_latency", 64'(cyc), 64'(RL + BPW));
    end
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while ((busy || exp_q.size() != 0) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(tag, 64'(cyc < 500), 64'd1);
    chk({tag, "_addr_left"}, 64'(addr_q.size()), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int cs_b;
    int cyc;
    bit saw;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[0] = 8'h42; mem[1] = 8'h8A; mem[2] = 8'h2F; mem[3] = 8'h98;
    mem[4] = 8'h71; mem[5] = 8'h37; mem[6] = 8'h44; mem[7] = 8'h91;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_rom_cs", 64'(rom_cs), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word fetch of the round-constant bytes.
    out_ready = 1'b1;
    do_req(10'h000, 2, 1'b1);
    wait_done("t1_done");

    // Back-pressure: only FIFO_DEPTH words may be reserved while the consumer stalls.
    out_ready = 1'b0;
    cs_b = cs_cnt;
    do_req(10'h040, 8, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("bp_cs_count", 64'(cs_cnt - cs_b), 64'(FD * BPW));
    chk("bp_rom_cs_low", 64'(rom_cs), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head_data", 64'(out_data), 64'(exp_q[0].data));
    out_ready = 1'b1;
    wait_done("t2_done");

    // Address wrap past the top of the macro.
    do_req(10'h3FE, 1, 1'b0);
    wait_done("t3_done");

    // Zero-length request: accepted, nothing happens.
    cs_b = cs_cnt;
    do_req(10'h020, 0, 1'b0);
    chk("len0_req_ready", 64'(req_ready), 64'd1);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || busy) saw = 1'b1;
    end
    chk("len0_quiet", 64'(saw), 64'd0);
    chk("len0_no_cs", 64'(cs_cnt - cs_b), 64'd0);

    // Reset in the middle of a burst.
    cs_b = cs_cnt;
    do_req(10'h100, 8, 1'b0);
    cyc = 0;
    while ((cs_cnt - cs_b) < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_reached", 64'(cyc < 100), 64'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_rom_cs", 64'(rom_cs), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(10'h200, 2, 1'b0);
    wait_done("t5_done");

    // Two words queued in DRAIN, then abort (or drain normally when abort is absent).
    out_ready = 1'b0;
    do_req(10'h010, 2, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("drain_queued_valid", 64'(out_valid), 64'd1);
`ifdef ROM_ABORT_EN
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    addr_q.delete();
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
`else
    out_ready = 1'b1;
    wait_done("t6_drain");
`endif
    out_ready = 1'b1;
    do_req(10'h3A0, 1, 1'b0);
    wait_done("t6_done");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
